// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle MIPS controller
package mc_ctrl_pkg;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ORIEX   = 4'd10;
    localparam logic [3:0] S_IMMWB   = 4'd11;
    localparam logic [3:0] S_JUMP    = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// rtl/mc_alu_dec.sv - maps aluop and funct onto the ALU control code
module mc_alu_dec
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTL_W = 3
) (
    input  logic [5:0]          funct,
    input  logic [1:0]          aluop,
    output logic [ALUCTL_W-1:0] alucontrol
);

    logic [2:0] code;

    always_comb begin
        code = ALUC_ADD;
        case (aluop)
            ALUOP_ADD: code = ALUC_ADD;
            ALUOP_SUB: code = ALUC_SUB;
            ALUOP_OR:  code = ALUC_OR;
            default: begin
                // unknown funct quietly falls back to add
                case (funct)
                    F_ADD:   code = ALUC_ADD;
                    F_SUB:   code = ALUC_SUB;
                    F_AND:   code = ALUC_AND;
                    F_OR:    code = ALUC_OR;
                    F_SLT:   code = ALUC_SLT;
                    default: code = ALUC_ADD;
                endcase
            end
        endcase
    end

    assign alucontrol = ALUCTL_W'(code);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle MIPS main decoder FSM with merged ALU decode
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTL_W      = 3,
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit EN_BNE        = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pcEnable,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                alusrca,
    output logic                iord,
    output logic                MemtoReg,
    output logic                regDST,
    output logic                zext,
    output logic [1:0]          alusrcb,
    output logic [1:0]          pcsrc,
    output logic [ALUCTL_W-1:0] alucontrol,
    output logic                illegal_op
);

    logic [3:0] state;
    logic [3:0] next_state;
    logic [3:0] decode_target;
    logic       op_valid;
    logic       ready;
    logic       isbne;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign isbne = (op == OP_BNE);

    always_comb begin
        op_valid      = 1'b1;
        decode_target = S_FETCH;
        case (op)
            OP_LW, OP_SW: decode_target = S_MEMADR;
            OP_RTYPE:     decode_target = S_RTYPEEX;
            OP_BEQ:       decode_target = S_BRANCH;
            OP_BNE: begin
                decode_target = EN_BNE ? S_BRANCH : S_FETCH;
                op_valid      = EN_BNE;
            end
            OP_ADDI:      decode_target = S_ADDIEX;
            OP_ORI:       decode_target = S_ORIEX;
            OP_J:         decode_target = S_JUMP;
            default:      op_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:   next_state = ready ? S_DECODE : S_FETCH;
            S_DECODE:  next_state = decode_target;
            S_MEMADR:  next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   next_state = ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   next_state = S_FETCH;
            S_MEMWR:   next_state = ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: next_state = S_ALUWB;
            S_ALUWB:   next_state = S_FETCH;
            S_BRANCH:  next_state = S_FETCH;
            S_ADDIEX:  next_state = S_IMMWB;
            S_ORIEX:   next_state = S_IMMWB;
            S_IMMWB:   next_state = S_FETCH;
            S_JUMP:    next_state = S_FETCH;
            default:   next_state = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        alusrca    = 1'b0;
        iord       = 1'b0;
        MemtoReg   = 1'b0;
        regDST     = 1'b0;
        zext       = 1'b0;
        alusrcb    = SRCB_B;
        pcsrc      = PCSRC_ALU;
        aluop      = ALUOP_ADD;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                alusrcb = SRCB_FOUR;
                IRWrite = ready;
                pcwrite = ready;
            end
            S_DECODE: begin
                alusrcb    = SRCB_BRIMM;
                illegal_op = !op_valid;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                MemWrite = ready;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                regDST   = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
                pcsrc   = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_ORIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                zext    = 1'b1;
                aluop   = ALUOP_OR;
            end
            S_IMMWB: RegWrite = 1'b1;
            S_JUMP: begin
                pcwrite = 1'b1;
                pcsrc   = PCSRC_JUMP;
            end
            default: ;
        endcase
        // a low reset aborts the instruction: no writes, neutral selects
        if (!reset) begin
            pcwrite    = 1'b0;
            branch     = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            alusrca    = 1'b0;
            iord       = 1'b0;
            MemtoReg   = 1'b0;
            regDST     = 1'b0;
            zext       = 1'b0;
            alusrcb    = SRCB_B;
            pcsrc      = PCSRC_ALU;
            aluop      = ALUOP_ADD;
            illegal_op = 1'b0;
        end
        pcEnable = pcwrite | (branch & (zero ^ isbne));
    end

    mc_alu_dec #(.ALUCTL_W(ALUCTL_W)) u_alu_dec (
        .funct      (funct),
        .aluop      (aluop),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, zero, mem_ready;
    logic [5:0] op, funct;
    logic       pcEnable, MemWrite, IRWrite, RegWrite, alusrca, iord;
    logic       MemtoReg, regDST, zext, illegal_op;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    logic       reset_nb, mem_ready_nb;
    logic [5:0] op_nb;
    logic       nb_pcen, nb_memw, nb_irw, nb_regw, nb_asa, nb_iord;
    logic       nb_m2r, nb_rdst, nb_zx, nb_ill;
    logic [1:0] nb_srcb, nb_pcs;
    logic [2:0] nb_aluc;

    mc_ctrl_fsm #(.ALUCTL_W(3), .MEM_HANDSHAKE(1'b1), .EN_BNE(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcEnable(pcEnable), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .alusrca(alusrca), .iord(iord),
        .MemtoReg(MemtoReg), .regDST(regDST), .zext(zext), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal_op(illegal_op)
    );

    mc_ctrl_fsm #(.ALUCTL_W(3), .MEM_HANDSHAKE(1'b1), .EN_BNE(1'b0)) dut_nb (
        .clk(clk), .reset(reset_nb), .op(op_nb), .funct(funct), .zero(zero),
        .mem_ready(mem_ready_nb), .pcEnable(nb_pcen), .MemWrite(nb_memw),
        .IRWrite(nb_irw), .RegWrite(nb_regw), .alusrca(nb_asa), .iord(nb_iord),
        .MemtoReg(nb_m2r), .regDST(nb_rdst), .zext(nb_zx), .alusrcb(nb_srcb),
        .pcsrc(nb_pcs), .alucontrol(nb_aluc), .illegal_op(nb_ill)
    );

    logic [17:0] dutv, nbv;
    assign dutv = {pcEnable, MemWrite, IRWrite, RegWrite, alusrca, iord, MemtoReg,
                   regDST, zext, alusrcb, pcsrc, alucontrol, illegal_op};
    assign nbv  = {nb_pcen, nb_memw, nb_irw, nb_regw, nb_asa, nb_iord, nb_m2r,
                   nb_rdst, nb_zx, nb_srcb, nb_pcs, nb_aluc, nb_ill};

    int errors = 0;
    int checks = 0;
    logic [17:0] exp_v, exp_nb;
    logic        exp_valid;
    string       ph_name, ph_nb;

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs of one named instruction step, straight from the step's description
    function automatic logic [17:0] expect_out(input string ph, input logic rdy, input logic z,
                                               input logic [5:0] o, input logic [5:0] f,
                                               input bit bne_en);
        logic pcen, memw, irw, regw, asa, iord_e, m2r, rdst, zx, ill;
        logic [1:0] srcb, pcs;
        logic [2:0] aluc;
        {pcen, memw, irw, regw, asa, iord_e, m2r, rdst, zx, ill} = '0;
        srcb = 2'b00; pcs = 2'b00; aluc = 3'b010;
        case (ph)
            "FETCH":   begin irw = rdy; pcen = rdy; srcb = 2'b01; end
            "DECODE":  begin
                srcb = 2'b11;
                ill = !((o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                   6'b001000, 6'b001101, 6'b000010}) ||
                        (o == 6'b000101 && bne_en));
            end
            "MEMADR":  begin asa = 1; srcb = 2'b10; end
            "MEMRD":   iord_e = 1;
            "MEMWB":   begin regw = 1; m2r = 1; end
            "MEMWR":   begin iord_e = 1; memw = rdy; end
            "RTYPEEX": begin asa = 1; aluc = funct_alu(f); end
            "ALUWB":   begin regw = 1; rdst = 1; end
            "BRANCH":  begin asa = 1; aluc = 3'b110; pcs = 2'b01; pcen = z ^ (o == 6'b000101); end
            "ADDIEX":  begin asa = 1; srcb = 2'b10; end
            "ORIEX":   begin asa = 1; srcb = 2'b10; zx = 1; aluc = 3'b001; end
            "IMMWB":   regw = 1;
            "JUMP":    begin pcen = 1; pcs = 2'b10; end
            default:   ;
        endcase
        return {pcen, memw, irw, regw, asa, iord_e, m2r, rdst, zx, srcb, pcs, aluc, ill};
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (dutv !== exp_v) begin
                errors++;
                $display("FAIL dut_%s t=%0t got=%b exp=%b", ph_name, $time, dutv, exp_v);
            end
        end
        checks++;
        if (nbv !== exp_nb) begin
            errors++;
            $display("FAIL nb_%s t=%0t got=%b exp=%b", ph_nb, $time, nbv, exp_nb);
        end
    end

    task automatic lit(input string name, input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, act, req);
        end
    endtask

    task automatic drive(input string ph, input logic rdy);
        reset = 1'b1; mem_ready = rdy; ph_name = ph;
        exp_v = expect_out(ph, rdy, zero, op, funct, 1'b1);
        exp_valid = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic drive_rst();
        reset = 1'b0; mem_ready = 1'b1; ph_name = "RESET";
        exp_v = expect_out("RESET", 1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
        exp_valid = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic adv();
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int fw, input int mw);
        op = o; funct = f; zero = z;
        for (int i = 0; i <= fw; i++) begin drive("FETCH", i == fw); adv(); end
        drive("DECODE", 1'b0); adv();
        case (o)
            6'b100011: begin
                drive("MEMADR", 1'b0); adv();
                for (int i = 0; i <= mw; i++) begin drive("MEMRD", i == mw); adv(); end
                drive("MEMWB", 1'b0); adv();
            end
            6'b101011: begin
                drive("MEMADR", 1'b0); adv();
                for (int i = 0; i <= mw; i++) begin drive("MEMWR", i == mw); adv(); end
            end
            6'b000000: begin drive("RTYPEEX", 1'b0); adv(); drive("ALUWB", 1'b0); adv(); end
            6'b000100, 6'b000101: begin drive("BRANCH", 1'b0); adv(); end
            6'b001000: begin drive("ADDIEX", 1'b0); adv(); drive("IMMWB", 1'b0); adv(); end
            6'b001101: begin drive("ORIEX", 1'b0); adv(); drive("IMMWB", 1'b0); adv(); end
            6'b000010: begin drive("JUMP", 1'b0); adv(); end
            default: ;
        endcase
    endtask

    task automatic nb_step(input string ph, input logic rst_n);
        reset_nb = rst_n; mem_ready_nb = 1'b1; ph_nb = ph;
        exp_nb = expect_out(ph, 1'b1, 1'b0, op_nb, 6'd0, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0; zero = 1'b0; mem_ready = 1'b1; op = 6'd0; funct = 6'd0;
        reset_nb = 1'b0; mem_ready_nb = 1'b1; op_nb = 6'b000101; ph_nb = "RESET";
        exp_nb = expect_out("RESET", 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        exp_valid = 1'b0; exp_v = '0; ph_name = "IDLE";
        @(posedge clk); #1;
        drive_rst(); adv();
        drive_rst(); lit("rst_aluc", alucontrol, 3'b010); adv();

        // lw with three wait cycles in MEMRD: 8 cycles in total
        run_instr(6'b100011, 6'd0, 1'b0, 0, 3);

        // reset asserted mid-MEMWB
        op = 6'b100011;
        drive("FETCH", 1'b1); adv(); drive("DECODE", 1'b0); adv();
        drive("MEMADR", 1'b0); adv(); drive("MEMRD", 1'b1); adv();
        drive_rst(); lit("rst_regwrite", {2'b0, RegWrite}, 3'b000); adv();
        drive_rst(); adv();
        drive("FETCH", 1'b1);
        lit("post_rst_irw_pcen", {1'b0, IRWrite, pcEnable}, 3'b011); adv();
        drive("DECODE", 1'b0); adv();
        drive("MEMADR", 1'b0); adv(); drive("MEMRD", 1'b1); adv();
        drive("MEMWB", 1'b0); adv();

        // R-type slt
        op = 6'b000000; funct = 6'b101010;
        drive("FETCH", 1'b1); adv(); drive("DECODE", 1'b0); adv();
        drive("RTYPEEX", 1'b0); lit("slt_aluc", alucontrol, 3'b111); adv();
        drive("ALUWB", 1'b0); lit("slt_wb", {1'b0, RegWrite, regDST}, 3'b011); adv();
        run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);
        run_instr(6'b000000, 6'b100100, 1'b0, 0, 0);
        run_instr(6'b000000, 6'b111111, 1'b0, 0, 0);

        // branches with zero high and low
        run_instr(6'b000100, 6'd0, 1'b1, 0, 0);
        run_instr(6'b000100, 6'd0, 1'b0, 0, 0);
        run_instr(6'b000101, 6'd0, 1'b1, 0, 0);
        op = 6'b000101; zero = 1'b0;
        drive("FETCH", 1'b1); adv(); drive("DECODE", 1'b0); adv();
        drive("BRANCH", 1'b0); lit("bne_taken", {1'b0, pcsrc}, 3'b001);
        lit("bne_pcen", {2'b0, pcEnable}, 3'b001); adv();

        // ori, with EN_BNE=0 instance running bne alongside
        fork
            begin
                op = 6'b001101;
                drive("FETCH", 1'b1); adv(); drive("DECODE", 1'b0); adv();
                drive("ORIEX", 1'b0);
                lit("ori_ex", {zext, alusrcb}, 3'b110);
                lit("ori_aluc", alucontrol, 3'b001); adv();
                drive("IMMWB", 1'b0); lit("ori_rdst", {2'b0, regDST}, 3'b000); adv();
            end
            begin
                nb_step("FETCH", 1'b1);
                nb_step("DECODE", 1'b1);
                nb_step("FETCH", 1'b1);
                nb_step("RESET", 1'b0);
            end
        join

        // illegal opcode, then j
        op = 6'b111111;
        drive("FETCH", 1'b1); adv();
        drive("DECODE", 1'b0); lit("ill_pulse", {2'b0, illegal_op}, 3'b001); adv();
        drive("FETCH", 1'b1);
        lit("ill_after", {illegal_op, RegWrite, MemWrite}, 3'b000); adv();
        op = 6'b000010;
        drive("DECODE", 1'b0); adv();
        drive("JUMP", 1'b0); lit("j_out", {pcEnable, pcsrc}, 3'b110); adv();

        // remaining opcodes with fetch and memory wait states
        run_instr(6'b101011, 6'd0, 1'b0, 2, 1);
        run_instr(6'b101011, 6'd0, 1'b0, 0, 0);
        run_instr(6'b001000, 6'd0, 1'b0, 1, 0);
        run_instr(6'b011111, 6'd0, 1'b0, 0, 0);
        run_instr(6'b100011, 6'd0, 1'b0, 1, 0);

        exp_valid = 1'b0;
        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Parametrised multicycle MIPS control unit with the main-decoder FSM and ALU decoder merged into one block. It sits beside the multicycle datapath and drives every datapath enable and mux select. It extends the current controller with addi, ori, j and bne, an optional memory-ready handshake for wait states, and an illegal-opcode pulse.

Parameters:
ALUCTL_W, 3, alucontrol width; the encodings below occupy bits [2:0], upper bits are 0
MEM_HANDSHAKE, 1, 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = mem_ready ignored, single-cycle memory
EN_BNE, 1, 1 = bne supported; 0 = opcode 000101 treated as illegal

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0]
zero  in  1  ALU zero flag, valid in BRANCH state
mem_ready  in  1  memory access completes this cycle
pcEnable  out  1  PC register write enable
MemWrite  out  1  data memory write
IRWrite  out  1  instruction register load
RegWrite  out  1  register file write
alusrca  out  1  0 = PC, 1 = register A
iord  out  1  0 = PC address, 1 = ALUOut address
MemtoReg  out  1  0 = ALUOut, 1 = MDR
regDST  out  1  0 = rt, 1 = rd
zext  out  1  1 = zero-extend immediate (ori)
alusrcb  out  2  00 = B, 01 = 4, 10 = ext imm, 11 = signext imm<<2
pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
alucontrol  out  ALUCTL_W  ALU operation
illegal_op  out  1  one-cycle pulse, unsupported opcode reached DECODE

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, BRANCH, ADDIEX, ORIEX, IMMWB, JUMP.
- Reset: while reset = 0 at a clock edge, state becomes FETCH. During any cycle with reset = 0, all write enables and illegal_op are forced to 0 (pcEnable, MemWrite, IRWrite, RegWrite). All selects are 0. alucontrol = 010.
- Reset mid-instruction aborts the instruction. No write occurs in the cycle where reset is low.
- Outputs are Moore, decoded from state, except:
  - pcEnable = pcWrite | (branch & (zero XOR isbne)), where isbne is op == 000101.
  - The ready gating described below.
- FETCH: iord = 0, alusrca = 0, alusrcb = 01, aluop = add, pcsrc = 00.
  - IRWrite and pcWrite are asserted only when the access completes (mem_ready = 1, or MEM_HANDSHAKE = 0).
  - The state holds in FETCH until the access completes, then moves to DECODE.
- DECODE: alusrca = 0, alusrcb = 11, aluop = add. Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BRANCH; 000101 -> BRANCH if EN_BNE
  - 001000 -> ADDIEX; 001101 -> ORIEX
  - 000010 -> JUMP
  - any other op -> FETCH, with illegal_op = 1 for exactly this cycle
- MEMADR: alusrca = 1, alusrcb = 10, add. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: iord = 1. Holds until ready, then goes to MEMWB.
- MEMWB: RegWrite = 1, MemtoReg = 1, regDST = 0, then FETCH.
- MEMWR: iord = 1. MemWrite is asserted only in the ready cycle (always asserted when MEM_HANDSHAKE = 0), then FETCH.
- RTYPEEX: alusrca = 1, alusrcb = 00, aluop = funct, then ALUWB.
- ALUWB: RegWrite = 1, regDST = 1, MemtoReg = 0, then FETCH.
- BRANCH: alusrca = 1, alusrcb = 00, sub, branch = 1, pcsrc = 01, then FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10, add, then IMMWB.
- ORIEX: alusrca = 1, alusrcb = 10, zext = 1, or, then IMMWB.
- IMMWB: RegWrite = 1, regDST = 0, MemtoReg = 0, then FETCH.
- JUMP: pcWrite = 1, pcsrc = 10, then FETCH.
- ALU decode:
  - aluop add -> 010; sub -> 110; or -> 001.
  - funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct -> 010, with no flag.
- mem_ready is a don't-care outside FETCH/MEMRD/MEMWR.
- Instruction latency: lw 5, sw 4, R-type 4, addi/ori 4, beq/bne 3, j 3 cycles (zero wait states).

Decomposition:
- Shared package/header mc_ctrl_pkg:
  - state encoding localparams (4-bit)
  - opcode and funct constants
  - aluop codes (2-bit: add, sub, funct, or)
  - alucontrol codes
  - alusrcb and pcsrc codes
- One sub-module: mc_alu_dec (funct, aluop -> alucontrol), instantiated once. The FSM and output decode stay in mc_ctrl_fsm.

Test Plan:
- Reset: reset = 0 for 2 cycles mid-MEMWB, then 1 -> RegWrite = 0 during reset. The first cycle after release is FETCH, with IRWrite = 1 and pcEnable = 1 (mem_ready = 1).
- lw (op 100011) with mem_ready low for 3 cycles in MEMRD -> state holds, iord = 1 throughout. MEMWB follows the ready cycle; total 8 cycles.
- R-type slt (op 000000, funct 101010) -> alucontrol = 111 in RTYPEEX, then ALUWB with RegWrite = 1 and regDST = 1.
- beq vs bne with zero = 1 then zero = 0:
  - beq: pcEnable = 1 only when zero = 1.
  - bne (EN_BNE = 1): pcEnable = 1 only when zero = 0.
  - bne with EN_BNE = 0: illegal_op pulses in DECODE.
- ori (op 001101) -> zext = 1, alusrcb = 10, alucontrol = 001 in ORIEX; IMMWB with regDST = 0.
- Illegal op 111111 -> illegal_op high exactly 1 cycle, no RegWrite/MemWrite, next state FETCH. j (000010) -> pcsrc = 10, pcEnable = 1 in JUMP.
